aemb2_dmem_lsu: RTL

- Load/store unit for the AEMB2 data Wishbone bus.
- Sits beside the integer unit:
  - Decodes LBU/LHU/LW/SB/SH/SW in the OF stage.
  - Issues the bus cycle in EX, using the integer unit's registered effective address.
  - Returns aligned load data in the MX stage for writeback.
- Generates the data-side feedback term that the pipeline controller ANDs into dena.

---
 rtl/aemb2_pkg.sv | 29 ++
 rtl/aemb2_dmem_align.sv | 53 +++++
 rtl/aemb2_dmem_lsu.sv | 107 ++++++++++
 3 files changed

// File: rtl/aemb2_pkg.sv
// Shared constants for the AEMB2 data-side load/store path: memory opcodes,
// access size encodings and the LSU bus state constants.
package aemb2_pkg;

  localparam logic [5:0] OPC_LBU  = 6'o60;
  localparam logic [5:0] OPC_LHU  = 6'o61;
  localparam logic [5:0] OPC_LW   = 6'o62;
  localparam logic [5:0] OPC_SB   = 6'o64;
  localparam logic [5:0] OPC_SH   = 6'o65;
  localparam logic [5:0] OPC_SW   = 6'o66;
  localparam logic [5:0] OPC_LBUI = 6'o70;
  localparam logic [5:0] OPC_LHUI = 6'o71;
  localparam logic [5:0] OPC_LWI  = 6'o72;
  localparam logic [5:0] OPC_SBI  = 6'o74;
  localparam logic [5:0] OPC_SHI  = 6'o75;
  localparam logic [5:0] OPC_SWI  = 6'o76;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic is_mem(input logic [5:0] opc);
    return opc[5:4] == 2'b11;
  endfunction

endpackage

// File: rtl/aemb2_dmem_align.sv
// Big-endian lane handling for the data bus: byte-lane select, store data
// replication and zero-extended load extraction. Size 3 behaves as word.
module aemb2_dmem_align
  import aemb2_pkg::*;
(
  input  logic [1:0]  acc_size,
  input  logic [1:0]  off,
  input  logic [1:0]  st_size,
  input  logic [31:0] opd,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel,
  output logic [31:0] st_dat,
  output logic [31:0] ld_dat
);

  always_comb begin
    sel    = '0;
    ld_dat = '0;
    case (acc_size)
      SZ_BYTE: begin
        case (off)
          2'd0: begin sel = 4'b1000; ld_dat = {24'h0, dat_i[31:24]}; end
          2'd1: begin sel = 4'b0100; ld_dat = {24'h0, dat_i[23:16]}; end
          2'd2: begin sel = 4'b0010; ld_dat = {24'h0, dat_i[15:8]};  end
          default: begin sel = 4'b0001; ld_dat = {24'h0, dat_i[7:0]}; end
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          sel    = 4'b0011;
          ld_dat = {16'h0, dat_i[15:0]};
        end else begin
          sel    = 4'b1100;
          ld_dat = {16'h0, dat_i[31:16]};
        end
      end
      default: begin
        sel    = 4'b1111;
        ld_dat = dat_i;
      end
    endcase
  end

  always_comb begin
    st_dat = opd;
    case (st_size)
      SZ_BYTE: st_dat = {4{opd[7:0]}};
      SZ_HALF: st_dat = {2{opd[15:0]}};
      default: st_dat = opd;
    endcase
  end

endmodule

// File: rtl/aemb2_dmem_lsu.sv
// AEMB2 data Wishbone load/store unit: decodes in OF, holds the bus cycle in EX,
// and registers aligned load data for MX writeback.
module aemb2_dmem_lsu
  import aemb2_pkg::*;
#(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_HTX = 1
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                dena,
  input  logic                gpha,
  input  logic [5:0]          opc_of,
  input  logic [31:0]         opd_of,
  input  logic [AEMB_DWB-1:2] mem_ex,
  input  logic [1:0]          alu_ex,
  output logic [AEMB_DWB-1:2] dwb_adr_o,
  output logic [3:0]          dwb_sel_o,
  output logic [31:0]         dwb_dat_o,
  output logic                dwb_stb_o,
  output logic                dwb_cyc_o,
  output logic                dwb_wre_o,
  output logic                dwb_tag_o,
  input  logic [31:0]         dwb_dat_i,
  input  logic                dwb_ack_i,
  output logic                dwb_fb,
  output logic [31:0]         dwb_mx
);

  logic [0:0]  state;
  logic        wre_q;
  logic        tag_q;
  logic [1:0]  size_q;
  logic [31:0] dat_q;
  logic [31:0] mx_q;

  logic        fmem;
  logic        fstr;
  logic [1:0]  fsize;
  logic        tag_in;
  logic        busy;
  logic        issue;
  logic        done;
  logic [3:0]  sel_raw;
  logic [31:0] st_dat;
  logic [31:0] ld_dat;
  logic        unused_opc;

  assign fmem       = is_mem(opc_of);
  assign fstr       = opc_of[2];
  assign fsize      = opc_of[1:0];
  assign tag_in     = (AEMB_HTX != 0) ? gpha : 1'b0;
  assign unused_opc = opc_of[3];

  assign busy  = (state == ST_BUSY);
  assign done  = busy & dwb_ack_i;
  // A new operation is accepted from idle, or in the ack cycle of the current
  // one so back-to-back accesses keep the strobe asserted without a gap.
  assign issue = dena & fmem & (~busy | dwb_ack_i);

  aemb2_dmem_align u_align (
    .acc_size (size_q),
    .off      (alu_ex),
    .st_size  (fsize),
    .opd      (opd_of),
    .dat_i    (dwb_dat_i),
    .sel      (sel_raw),
    .st_dat   (st_dat),
    .ld_dat   (ld_dat)
  );

  always_ff @(posedge gclk) begin
    if (grst) begin
      state  <= ST_IDLE;
      wre_q  <= 1'b0;
      tag_q  <= 1'b0;
      size_q <= SZ_BYTE;
      dat_q  <= '0;
      mx_q   <= '0;
    end else begin
      if (done && !wre_q)
        mx_q <= ld_dat;
      if (issue) begin
        state  <= ST_BUSY;
        wre_q  <= fstr;
        tag_q  <= tag_in;
        size_q <= fsize;
        dat_q  <= st_dat;
      end else if (done) begin
        state <= ST_IDLE;
        wre_q <= 1'b0;
        tag_q <= 1'b0;
      end
    end
  end

  assign dwb_adr_o = mem_ex;
  assign dwb_sel_o = busy ? sel_raw : 4'b0000;
  assign dwb_dat_o = dat_q;
  assign dwb_stb_o = busy;
  assign dwb_cyc_o = busy;
  assign dwb_wre_o = wre_q;
  assign dwb_tag_o = tag_q;
  assign dwb_fb    = ~busy | dwb_ack_i;
  assign dwb_mx    = mx_q;

endmodule
